mux32_scanner: RTL
==================

MUX32_SCANNER -- requirements
Module: mux32_scanner

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1: cycles each select value is held before mux output is sampled; legal range 1..16.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous assert, active-low.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a 32-input scan.
REQ-005 SHALL have port select  output  5  drives mux32 select.
REQ-006 SHALL have port mux_out  input  1  mux32 output bit.
REQ-007 SHALL have port word  output  32  assembled scan result; bit i holds mux_out sampled with select == i.
REQ-008 SHALL have port valid  output  1  word is complete and held.
REQ-009 SHALL have port ready  input  1  consumer accepts word.
REQ-010 SHALL have port busy  output  1  scan in progress.

Function
REQ-011 SHALL implement states IDLE, SCAN, DONE.
REQ-012 In IDLE: select=0, busy=0, valid=0; start=1 -> SCAN, select=0, settle counter=SETTLE_CYCLES-1, word cleared to 0.
REQ-013 In SCAN: busy=1, valid=0; counter!=0 -> counter decrements, select held.
REQ-014 In SCAN with counter==0: word[select] <= mux_out; select<31 -> select+1, counter reloaded; select==31 -> DONE, select held at 31.
REQ-015 Latency: valid SHALL be high starting 32*SETTLE_CYCLES rising edges after the edge that sampled start.
REQ-016 In DONE: valid=1, busy=0, word and select stable; valid&&ready on an edge -> IDLE, valid low next cycle.
REQ-017 valid SHALL stay high and word unchanged for any number of cycles with ready=0.
REQ-018 start SHALL be ignored in SCAN and DONE, including start and ready asserted together in DONE (next state IDLE, no new scan).
REQ-019 ready SHALL be ignored outside DONE.
REQ-020 select SHALL never wrap past 31 and SHALL change only on rising edges.
REQ-021 mux_out SHALL be sampled only on capture edges (REQ-014); changes at other times SHALL NOT affect word.

Reset
REQ-022 rst low SHALL immediately force IDLE, select=0, counter=0, word=0, valid=0, busy=0, regardless of state, including mid-scan.
REQ-023 After rst deasserts, the block SHALL require a fresh start; no partial scan resumes.

Structure
REQ-024 Shared package scanner_pkg SHALL hold the state enum (IDLE, SCAN, DONE), N_INPUTS=32 and SELECT_W=5.
REQ-025 Block SHALL be a single module with no sub-modules; mux32 is instantiated alongside it only in the bench top.
REQ-026 Settle counter SHALL be 4 bits; select register SELECT_W bits.

Verification
REQ-027 Bench SHALL connect mux32_scanner to mux32 and cover:
- Odd inputs 1, even 0, SETTLE_CYCLES=1, start pulse, ready=1 -> valid after 32 edges, word=0xAAAAAAAA, then IDLE.
- inputs=0x12345678, SETTLE_CYCLES=3 -> valid exactly 96 edges after start, word=0x12345678, select observed stepping every 3 cycles.
- Scan complete, ready=0 for 10 cycles, then 1 -> valid and word=0xAAAAAAAA stable throughout, valid low cycle after acceptance.
- start pulsed at select=10 mid-scan, and again with ready in DONE -> no restart; busy/valid timing identical to unperturbed run; IDLE after DONE.
- rst low at select=15 -> word=0, valid=0, busy=0, select=0 immediately; new start after release yields full correct word.
- Inputs toggled between capture edges while select held (SETTLE_CYCLES=2, changed only on non-capture cycle then restored) -> word equals values present on capture edges.

Source files
------------

// File: rtl/scanner_pkg.sv
// Shared definitions for the mux32 scanner.
// Holds the scanner state encoding, the number of mux inputs, the select
// width and the settle-counter width.
package scanner_pkg;

  localparam int N_INPUTS = 32;
  localparam int SELECT_W = 5;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : scanner_pkg

// File: rtl/mux32.sv
// 32:1 single-bit multiplexer. It is the device the scanner walks through.
// Ports:
//   i_data  32 candidate input bits
//   i_sel   select, picks i_data[i_sel]
//   o_out   selected bit
module mux32 (
  input  logic [31:0] i_data,
  input  logic [4:0]  i_sel,
  output logic        o_out
);

  assign o_out = i_data[i_sel];

endmodule : mux32

// File: rtl/mux32_scanner.sv
// Walks an external 32:1 mux through all of its select values and assembles
// the sampled bits into a 32-bit word. Each select value is held for
// SETTLE_CYCLES cycles. The bit is sampled on the last edge of that window.
// The finished word is presented with valid until the consumer takes it
// with ready.
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-low reset
//   start    one-cycle request to begin a scan (honoured only in IDLE)
//   select   mux select being driven
//   mux_out  mux output bit
//   word     assembled result, bit i = mux_out sampled with select == i
//   valid    word complete and held
//   ready    consumer accepts word (honoured only in DONE)
//   busy     scan in progress
module mux32_scanner
  import scanner_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [SELECT_W-1:0] select,
  input  logic                mux_out,
  output logic [31:0]         word,
  output logic                valid,
  input  logic                ready,
  output logic                busy
);

  localparam logic [CNT_W-1:0]    RELOAD   = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [SELECT_W-1:0] LAST_SEL = SELECT_W'(N_INPUTS - 1);

  state_t                r_state;
  logic [SELECT_W-1:0]   r_select;
  logic [CNT_W-1:0]      r_cnt;
  logic [N_INPUTS-1:0]   r_word;

  state_t                w_state_nxt;
  logic [SELECT_W-1:0]   w_select_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [N_INPUTS-1:0]   w_word_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_select <= '0;
      r_cnt    <= '0;
      r_word   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_select <= w_select_nxt;
      r_cnt    <= w_cnt_nxt;
      r_word   <= w_word_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_select_nxt = r_select;
    w_cnt_nxt    = r_cnt;
    w_word_nxt   = r_word;
    case (r_state)
      IDLE: begin
        w_select_nxt = '0;
        if (start) begin
          w_state_nxt = SCAN;
          w_cnt_nxt   = RELOAD;
          w_word_nxt  = '0;
        end
      end
      SCAN: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          // Capture edge: the select has been stable for the full window.
          w_word_nxt[r_select] = mux_out;
          if (r_select != LAST_SEL) begin
            w_select_nxt = r_select + 1'b1;
            w_cnt_nxt    = RELOAD;
          end else begin
            // Select stays at 31 while the word is presented.
            w_state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (ready) begin
          w_state_nxt  = IDLE;
          w_select_nxt = '0;
          w_cnt_nxt    = '0;
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_select_nxt = '0;
        w_cnt_nxt    = '0;
      end
    endcase
  end

  assign select = r_select;
  assign word   = r_word;
  assign valid  = (r_state == DONE);
  assign busy   = (r_state == SCAN);

endmodule : mux32_scanner
